// File: rtl/snn_pkg.sv
// Shared types and defaults for the potential-adder neuron core scheduler.
package snn_pkg;

    localparam int N_DEF       = 8;
    localparam int W_DEF       = 32;
    localparam int T_STEPS_DEF = 350;
    localparam int TCW_DEF     = 9;

    typedef enum logic [3:0] {
        S_IDLE,
        S_INIT,
        S_SEL,
        S_P1_W,
        S_P2_W,
        S_P3A_W,
        S_ARG,
        S_P3B_W,
        S_TEND,
        S_DONE
    } state_e;

    typedef enum logic [1:0] {
        PP1 = 2'd1,
        PP2 = 2'd2,
        PP3 = 2'd3
    } phase_e;

    // No input spikes means decay only; otherwise the learn flag picks
    // inference or learning accumulation.
    function automatic phase_e sel_phase(input logic ip_any, input logic learn);
        if (!ip_any)
            return PP1;
        else if (learn)
            return PP3;
        else
            return PP2;
    endfunction

endpackage

// File: rtl/pp_argmax_seq.sv
// Serial signed argmax over N packed potentials, one neuron per cycle.
// The start cycle examines neuron 0; done is raised combinationally in the
// cycle that examines neuron N-1, with best_idx already holding the result.
module pp_argmax_seq #(
    parameter int N = 8,
    parameter int W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [N*W-1:0]       potential,
    output logic                 done,
    output logic [$clog2(N)-1:0] best_idx
);
    localparam int IW = $clog2(N);
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    logic signed [W-1:0] pot [N];
    logic signed [W-1:0] cur_val;
    logic signed [W-1:0] best_val;
    logic [IW-1:0]       idx;
    logic [IW-1:0]       cur_idx;
    logic [IW-1:0]       best;
    logic                run;
    logic                take;

    for (genvar g = 0; g < N; g++) begin : g_unpack
        assign pot[g] = potential[W*g +: W];
    end

    // Candidate for this cycle; ties keep the earlier (lower) index.
    always_comb begin
        cur_idx  = start ? '0 : idx;
        cur_val  = pot[cur_idx];
        take     = start || (cur_val > best_val);
        best_idx = take ? cur_idx : best;
        done     = (start || run) && (cur_idx == LAST);
    end

    // Scan control: index walks 1..N-1 after the start cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run <= 1'b0;
            idx <= '0;
        end else if (start) begin
            run <= (N > 1);
            idx <= IW'(1);
        end else if (run) begin
            if (idx == LAST)
                run <= 1'b0;
            else
                idx <= idx + 1'b1;
        end
    end

    // Running best value/index, only meaningful while a scan is active.
    always_ff @(posedge clk) begin
        if (start || run) begin
            best     <= best_idx;
            best_val <= take ? cur_val : best_val;
        end
    end

endmodule

// File: rtl/pp_phase_sched.sv
// Time-unit scheduler for the potential-adder neuron bank: sequences
// decay / inference / learning phases per TU, tracks outstanding neurons,
// and runs winner-take-all between the two learning sub-phases.
module pp_phase_sched
    import snn_pkg::*;
#(
    parameter int N       = N_DEF,
    parameter int W       = W_DEF,
    parameter int T_STEPS = T_STEPS_DEF,
    parameter int TCW     = TCW_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_img,
    input  logic                 learn,
    input  logic                 ip_any,
    input  logic [N-1:0]         valid_pp1,
    input  logic [N-1:0]         valid_pp2,
    input  logic [N-1:0]         valid_pp3m,
    input  logic [N-1:0]         valid_pp3,
    input  logic [N-1:0]         spike_pp,
    input  logic [N*W-1:0]       potential,
    output logic                 start_core_img,
    output logic                 start_pp1,
    output logic                 start_pp2,
    output logic                 start_pp3,
    output logic                 start_pp3m,
    output logic [N-1:0]         won_lost_hold,
    output logic                 TU_incre,
    output logic [TCW-1:0]       tu_count,
    output logic [N-1:0]         spike_vec,
    output logic [$clog2(N)-1:0] winner_idx,
    output logic                 busy,
    output logic                 img_done
);
    localparam int IW = $clog2(N);

    state_e         state;
    logic [N-1:0]   pend;
    logic [N-1:0]   phase_valid;
    logic [N-1:0]   accepted;
    logic [N-1:0]   pend_next;
    logic           learn_q;
    logic           arg_start;
    logic           arg_done;
    logic [IW-1:0]  arg_best;

    pp_argmax_seq #(
        .N (N),
        .W (W)
    ) u_argmax (
        .clk       (clk),
        .rst       (rst),
        .start     (arg_start),
        .potential (potential),
        .done      (arg_done),
        .best_idx  (arg_best)
    );

    // Only the valid vector of the phase being waited on can retire neurons.
    always_comb begin
        phase_valid = '0;
        case (state)
            S_P1_W:  phase_valid = valid_pp1;
            S_P2_W:  phase_valid = valid_pp2;
            S_P3A_W: phase_valid = valid_pp3m;
            S_P3B_W: phase_valid = valid_pp3;
            default: phase_valid = '0;
        endcase
        accepted  = pend & phase_valid;
        pend_next = pend & ~phase_valid;
    end

    // Main scheduler FSM; all outputs are registered and pulses self-clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= S_IDLE;
            pend           <= '0;
            learn_q        <= 1'b0;
            arg_start      <= 1'b0;
            start_core_img <= 1'b0;
            start_pp1      <= 1'b0;
            start_pp2      <= 1'b0;
            start_pp3      <= 1'b0;
            start_pp3m     <= 1'b0;
            won_lost_hold  <= '0;
            TU_incre       <= 1'b0;
            tu_count       <= '0;
            spike_vec      <= '0;
            winner_idx     <= '0;
            busy           <= 1'b0;
            img_done       <= 1'b0;
        end else begin
            start_core_img <= 1'b0;
            start_pp1      <= 1'b0;
            start_pp2      <= 1'b0;
            start_pp3      <= 1'b0;
            start_pp3m     <= 1'b0;
            TU_incre       <= 1'b0;
            img_done       <= 1'b0;
            arg_start      <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start_img) begin
                        learn_q        <= learn;
                        busy           <= 1'b1;
                        start_core_img <= 1'b1;
                        state          <= S_INIT;
                    end
                end
                S_INIT: begin
                    tu_count <= '0;
                    state    <= S_SEL;
                end
                S_SEL: begin
                    pend      <= '1;
                    spike_vec <= '0;
                    case (sel_phase(ip_any, learn_q))
                        PP2: begin
                            start_pp2 <= 1'b1;
                            state     <= S_P2_W;
                        end
                        PP3: begin
                            start_pp3 <= 1'b1;
                            state     <= S_P3A_W;
                        end
                        default: begin
                            start_pp1 <= 1'b1;
                            state     <= S_P1_W;
                        end
                    endcase
                end
                S_P1_W, S_P2_W, S_P3B_W: begin
                    pend <= pend_next;
                    if (state != S_P1_W)
                        spike_vec <= spike_vec | (spike_pp & accepted);
                    if (pend_next == '0) begin
                        TU_incre <= 1'b1;
                        state    <= S_TEND;
                    end
                end
                S_P3A_W: begin
                    pend <= pend_next;
                    if (pend_next == '0) begin
                        arg_start <= 1'b1;
                        state     <= S_ARG;
                    end
                end
                S_ARG: begin
                    if (arg_done) begin
                        won_lost_hold <= N'(1) << arg_best;
                        winner_idx    <= arg_best;
                        start_pp3m    <= 1'b1;
                        pend          <= '1;
                        state         <= S_P3B_W;
                    end
                end
                S_TEND: begin
                    if (tu_count == TCW'(T_STEPS - 1)) begin
                        img_done <= 1'b1;
                        state    <= S_DONE;
                    end else begin
                        tu_count <= tu_count + 1'b1;
                        state    <= S_SEL;
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
